pwm_multi_channel: RTL and testbench
====================================

# pwm_multi_channel

Parametrised multi-channel PWM generator, the successor to the team's single-channel fixed-8-bit PWM. All CHANNELS outputs share one timebase counter. Period, per-channel duty, alignment mode and per-channel polarity are runtime-programmable. They pass through shadow registers and take effect only at a period boundary, so outputs never glitch. The block sits between a register/control block (which drives the load strobe) and motor, LED or power-stage pins.

## Interface
- WIDTH, 8: counter, period and duty width in bits (2..16).
- CHANNELS, 4: number of PWM outputs (1..16).
- clock  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- enable  in  1  1 = run timebase; 0 = hold idle.
- load  in  1  one-cycle strobe; captures the configuration inputs below into staging.
- mode  in  1  0 = edge-aligned, 1 = center-aligned.
- period  in  WIDTH  top count P.
- duty  in  CHANNELS*WIDTH  channel i duty D[i] = duty[i*WIDTH +: WIDTH].
- polarity  in  CHANNELS  0 = active-high, 1 = active-low (inverted).
- pwm_output  out  CHANNELS  registered PWM outputs.
- period_done  out  1  one-cycle pulse in the final cycle of each period.

## Operation
- **Staging.** On load=1, mode/period/duty/polarity are copied into staging registers and the pending flag is set. If load fires several times before a boundary, the last capture wins.
- **Commit.** On the edge that ends the period (period_done=1) with pending set, staging is copied to the active registers and pending is cleared. If load coincides with period_done, the values presented that cycle are committed at that boundary (bypass).
- **Commit while disabled.** When enable=0, pending commits on the next edge.
- **Edge mode.** Counter runs 0,1,..,P, then wraps to 0. Period = P+1 cycles. Raw active = (counter < D[i]).
  - D=0 gives 0%.
  - D>P gives 100%.
- **Center mode.** Counter runs up 0..P, then down P-1..1, then returns to 0 with direction up. Period = 2P cycles. Raw active = (counter < D[i]).
  - High time = 2D-1 cycles for 1≤D≤P.
  - High time = 0 for D=0.
  - High time = 2P for D>P.
- **P=0 (either mode).** Counter held at 0; period_done=1 every enabled cycle.
- **Output level.** pwm_output[i] = raw_active XOR polarity[i], using the active polarity register.
- **enable=0.**
  - Counter forced to 0, direction up.
  - pwm_output[i] = polarity[i] (inactive level).
  - period_done=0.
- **enable 0→1.** Counter starts at 0 on the first enabled cycle.

## Timing
- **Reset values.**
  - counter=0, direction up, pending=0.
  - Active period = 2^WIDTH-1, all duties 0, mode edge, polarity 0.
  - pwm_output = 0, period_done = 0.
- **Reset mid-period.** Abandons the period immediately; staged values are discarded.
- **Output latency.** pwm_output is registered: its value in cycle t+1 reflects the counter and active registers in cycle t.
- **period_done.** Registered with the same one-cycle latency. It is decoded in the final cycle:
  - edge mode: counter==P;
  - center mode: counter==1 while counting down, or counter==P when P==1.
- **Commit visibility.** New configuration drives the compare from the first cycle of the next period, and therefore appears on pwm_output one cycle later.
- **Wrap arithmetic.** Counter is WIDTH bits; comparisons are unsigned. P=2^WIDTH-1 must wrap correctly without overflow.

## Structure
- **Shared package pwm_pkg:**
  - MODE_EDGE=1'b0, MODE_CENTER=1'b1;
  - DIR_UP/DIR_DOWN encodings;
  - default WIDTH constant.
- **Top level:** pwm_multi_channel holds the timebase counter/direction FSM (UP, DOWN, IDLE), staging/active registers, pending flag and period_done.
- **Sub-module:** pwm_channel_compare, instantiated CHANNELS times via generate. It holds the per-channel active duty/polarity and registers the compare into pwm_output[i].

## Test plan
- **Edge mode, 4 channels.** WIDTH=8, edge, P=9, D={0,5,10,3}, polarity 0, enable=1.
  - ch0 constantly 0; ch1 high 5 of 10 cycles; ch2 constantly 1; ch3 high 3 of 10.
  - period_done every 10 cycles.
- **Center mode.** P=4, D=2.
  - Period 8 cycles; ch high 3 cycles, centred on counter=0.
  - D=5 gives 8/8 high; D=0 gives 0/8 high.
- **Shadow update.** Running edge P=9 D=5; at cycle 3 of a period, load D=8.
  - Current period keeps 5 high cycles; the next period shows 8.
  - load coincident with period_done commits at that same boundary.
- **Polarity and enable.** polarity=4'b1010, then enable=0.
  - ch1 and ch3 idle high, ch0 and ch2 idle low.
  - Re-enable: counter restarts at 0 and the first period is full length.
- **Boundaries.**
  - P=0: period_done high every enabled cycle.
  - P=255, D=255: 255 high of 256, no overflow.
  - reset_n low mid-period: all outputs 0 on the next edge; pending discarded.

Source files
------------

// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_pkg
//  Purpose  : Shared encodings for the multi-channel PWM block: alignment
//             mode, count direction, timebase FSM states and default width.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package pwm_pkg;

  localparam int   DEFAULT_WIDTH = 8;

  localparam logic MODE_EDGE     = 1'b0;
  localparam logic MODE_CENTER   = 1'b1;

  localparam logic DIR_UP        = 1'b0;
  localparam logic DIR_DOWN      = 1'b1;

  // Timebase FSM. IDLE is held while disabled; it counts like UP once
  // enable returns, so the first enabled cycle sees counter 0.
  typedef enum logic [1:0] {
    TB_IDLE = 2'd0,
    TB_UP   = 2'd1,
    TB_DOWN = 2'd2
  } tb_state_e;

endpackage
`default_nettype wire

// File: rtl/pwm_channel_compare.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_channel_compare
//  Purpose  : One PWM channel. Holds the active duty and polarity for the
//             channel and registers (count < duty) ^ polarity into the pin.
//  Ports    : clock_i      system clock
//             reset_n_i    synchronous active-low reset
//             enable_i     timebase running; when low the pin idles
//             commit_i     load duty_i/polarity_i into the active registers
//             duty_i       duty value to commit
//             polarity_i   polarity value to commit (1 = active-low)
//             count_i      shared timebase counter
//             pwm_o        registered PWM output
//  Revision : 1.0  initial release
// ============================================================================
module pwm_channel_compare #(
  parameter int WIDTH = 8
) (
  input  logic             clock_i,
  input  logic             reset_n_i,
  input  logic             enable_i,
  input  logic             commit_i,
  input  logic [WIDTH-1:0] duty_i,
  input  logic             polarity_i,
  input  logic [WIDTH-1:0] count_i,
  output logic             pwm_o
);

  logic [WIDTH-1:0] duty_q;
  logic             pol_q;
  logic             pwm_q;
  logic             pwm_d;

  // While disabled the pin rests at its inactive level, which equals the
  // polarity bit itself.
  always_comb begin
    pwm_d = pol_q;
    if (enable_i) begin
      pwm_d = (count_i < duty_q) ^ pol_q;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      duty_q <= '0;
      pol_q  <= 1'b0;
      pwm_q  <= 1'b0;
    end else begin
      pwm_q <= pwm_d;
      if (commit_i) begin
        duty_q <= duty_i;
        pol_q  <= polarity_i;
      end
    end
  end

  assign pwm_o = pwm_q;

endmodule
`default_nettype wire

// File: rtl/pwm_multi_channel.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_multi_channel
//  Purpose  : CHANNELS PWM outputs on one shared timebase. Configuration is
//             staged on load and committed only at a period boundary (or at
//             once while disabled) so outputs never glitch.
//  Ports    : clock_i        system clock
//             reset_n_i      synchronous active-low reset
//             enable_i       1 = run timebase, 0 = idle
//             load_i         one-cycle strobe capturing the config inputs
//             mode_i         0 = edge-aligned, 1 = center-aligned
//             period_i       top count P
//             duty_i         packed per-channel duty, WIDTH bits each
//             polarity_i     per-channel polarity, 1 = active-low
//             pwm_output_o   registered PWM outputs
//             period_done_o  one-cycle pulse marking the final period cycle
//  Revision : 1.0  initial release
// ============================================================================
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int CHANNELS = 4
) (
  input  logic                      clock_i,
  input  logic                      reset_n_i,
  input  logic                      enable_i,
  input  logic                      load_i,
  input  logic                      mode_i,
  input  logic [WIDTH-1:0]          period_i,
  input  logic [CHANNELS*WIDTH-1:0] duty_i,
  input  logic [CHANNELS-1:0]       polarity_i,
  output logic [CHANNELS-1:0]       pwm_output_o,
  output logic                      period_done_o
);

  tb_state_e                 state_q, state_d;
  logic [WIDTH-1:0]          count_q, count_d;

  logic                      mode_q;
  logic [WIDTH-1:0]          period_q;

  logic                      stg_mode_q;
  logic [WIDTH-1:0]          stg_period_q;
  logic [CHANNELS*WIDTH-1:0] stg_duty_q;
  logic [CHANNELS-1:0]       stg_pol_q;
  logic                      pending_q;

  logic                      period_done_q;

  logic                      dir;
  logic                      last_cycle;
  logic                      commit;
  logic                      src_mode;
  logic [WIDTH-1:0]          src_period;
  logic [CHANNELS*WIDTH-1:0] src_duty;
  logic [CHANNELS-1:0]       src_pol;

  assign dir = (state_q == TB_DOWN) ? DIR_DOWN : DIR_UP;

  // Final cycle of the current period. In center mode with P<=1 there is
  // no down leg, so the top count itself ends the period.
  always_comb begin
    last_cycle = 1'b0;
    if (enable_i) begin
      if (mode_q == MODE_EDGE) begin
        last_cycle = (count_q == period_q);
      end else begin
        last_cycle = ((dir == DIR_DOWN) && (count_q == WIDTH'(1))) ||
                     ((count_q == period_q) && (period_q < WIDTH'(2)));
      end
    end
  end

  // A load in the boundary cycle bypasses staging so its values commit at
  // that same boundary. A disabled timebase is always at a boundary.
  assign commit     = (last_cycle || !enable_i) && (pending_q || load_i);
  assign src_mode   = load_i ? mode_i     : stg_mode_q;
  assign src_period = load_i ? period_i   : stg_period_q;
  assign src_duty   = load_i ? duty_i     : stg_duty_q;
  assign src_pol    = load_i ? polarity_i : stg_pol_q;

  // Timebase next state. count_q never exceeds period_q, so the increment
  // only happens below P and cannot overflow at P = 2^WIDTH-1.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (!enable_i) begin
      state_d = TB_IDLE;
      count_d = '0;
    end else if (last_cycle) begin
      state_d = TB_UP;
      count_d = '0;
    end else if ((mode_q == MODE_CENTER) && (dir == DIR_DOWN)) begin
      state_d = TB_DOWN;
      count_d = count_q - WIDTH'(1);
    end else if ((mode_q == MODE_CENTER) && (count_q == period_q)) begin
      state_d = TB_DOWN;
      count_d = count_q - WIDTH'(1);
    end else begin
      state_d = TB_UP;
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q       <= TB_IDLE;
      count_q       <= '0;
      mode_q        <= MODE_EDGE;
      period_q      <= '1;
      stg_mode_q    <= MODE_EDGE;
      stg_period_q  <= '1;
      stg_duty_q    <= '0;
      stg_pol_q     <= '0;
      pending_q     <= 1'b0;
      period_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      period_done_q <= last_cycle;
      if (load_i) begin
        stg_mode_q   <= mode_i;
        stg_period_q <= period_i;
        stg_duty_q   <= duty_i;
        stg_pol_q    <= polarity_i;
        pending_q    <= 1'b1;
      end
      // Placed after the staging update so a commit always clears pending.
      if (commit) begin
        mode_q    <= src_mode;
        period_q  <= src_period;
        pending_q <= 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    pwm_channel_compare #(
      .WIDTH(WIDTH)
    ) u_cmp (
      .clock_i    (clock_i),
      .reset_n_i  (reset_n_i),
      .enable_i   (enable_i),
      .commit_i   (commit),
      .duty_i     (src_duty[gi*WIDTH +: WIDTH]),
      .polarity_i (src_pol[gi]),
      .count_i    (count_q),
      .pwm_o      (pwm_output_o[gi])
    );
  end

  assign period_done_o = period_done_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi_channel.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_multi_channel
//  Purpose  : Self-checking bench for pwm_multi_channel (WIDTH=8, 4 channels)
//  Revision : 1.0  initial release
// ============================================================================
module tb_pwm_multi_channel;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           en;
  logic           load;
  logic           mode;
  logic [W-1:0]   period;
  logic [N*W-1:0] duty;
  logic [N-1:0]   pol;
  logic [N-1:0]   pwm;
  logic           done;

  always #5 clk = ~clk;

  pwm_multi_channel #(.WIDTH(W), .CHANNELS(N)) dut (
    .clock_i       (clk),
    .reset_n_i     (rst_n),
    .enable_i      (en),
    .load_i        (load),
    .mode_i        (mode),
    .period_i      (period),
    .duty_i        (duty),
    .polarity_i    (pol),
    .pwm_output_o  (pwm),
    .period_done_o (done)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (period-phase view) ----------------
  int         m_P, s_P, k;
  bit         m_mode, s_mode, s_pend, m_valid;
  int         m_D[N];
  int         s_D[N];
  bit [N-1:0] m_pol, s_pol;
  logic [N-1:0] exp_pwm;
  logic         exp_done;

  initial begin
    m_valid = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_P = 255; m_mode = 0; m_pol = '0; s_pend = 0; k = 0;
        for (int i = 0; i < N; i++) m_D[i] = 0;
        exp_pwm = '0; exp_done = 1'b0;
      end else begin
        int  len, cnt;
        bit  last;
        // Period length in cycles, and the counter value at phase k.
        len  = (m_mode == 0) ? m_P + 1 : ((m_P == 0) ? 1 : 2 * m_P);
        cnt  = (m_mode == 0 || k <= m_P) ? k : 2 * m_P - k;
        last = en && (k == len - 1);
        for (int i = 0; i < N; i++)
          exp_pwm[i] = en ? ((cnt < m_D[i]) ^ m_pol[i]) : m_pol[i];
        exp_done = last;
        k = (!en || last) ? 0 : k + 1;
        if (load) begin
          s_mode = mode; s_P = int'(period); s_pol = pol; s_pend = 1;
          for (int i = 0; i < N; i++) s_D[i] = int'(duty[i*W +: W]);
        end
        if ((last || !en) && s_pend) begin
          m_mode = s_mode; m_P = s_P; m_pol = s_pol; s_pend = 0;
          for (int i = 0; i < N; i++) m_D[i] = s_D[i];
        end
      end
      m_valid = 1;
      @(negedge clk);
      if (m_valid) begin
        chk("pwm_output", int'(pwm), int'(exp_pwm));
        chk("period_done", int'(done), int'(exp_done));
      end
    end
  end

  // ---------------- directed helpers ----------------
  int win_ones[N];
  int win_done;

  task automatic cfg(input bit md, input int p, input logic [N*W-1:0] d,
                     input logic [N-1:0] pl);
    mode = md; period = W'(p); duty = d; pol = pl; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_done(input int bound, input string name);
    int n;
    n = 0;
    while (n < bound) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    if (n >= bound && !done) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: no period_done within %0d cycles", name, bound);
    end
  endtask

  // Observes n output cycles; optionally pulses load with a new duty
  // after sample load_at.
  task automatic window(input int n, input int load_at, input logic [N*W-1:0] ld);
    for (int c = 0; c < N; c++) win_ones[c] = 0;
    win_done = 0;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      for (int c = 0; c < N; c++) win_ones[c] += int'(pwm[c]);
      win_done += int'(done);
      if (j == load_at) begin duty = ld; load = 1'b1; end
      else load = 1'b0;
    end
    load = 1'b0;
  endtask

  task automatic cycles_to_done(input int bound, output int n);
    n = 0;
    while (n < bound) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0; en = 1'b0; load = 1'b0; mode = 1'b0;
    period = '0; duty = '0; pol = '0;
    repeat (3) @(negedge clk);
    chk("reset_pwm", int'(pwm), 0);
    chk("reset_done", int'(done), 0);
    rst_n = 1'b1;

    // Edge mode, P=9, D={0,5,10,3}
    cfg(0, 9, {8'd3, 8'd10, 8'd5, 8'd0}, 4'b0000);
    en = 1'b1;
    wait_done(600, "edge_sync");
    window(10, -1, '0);
    chk("edge_ch0_high", win_ones[0], 0);
    chk("edge_ch1_high", win_ones[1], 5);
    chk("edge_ch2_high", win_ones[2], 10);
    chk("edge_ch3_high", win_ones[3], 3);
    chk("edge_done_per_period", win_done, 1);

    // Center mode, P=4, D={2,5,0,4}
    cfg(1, 4, {8'd4, 8'd0, 8'd5, 8'd2}, 4'b0000);
    wait_done(600, "center_sync");
    window(8, -1, '0);
    chk("center_D2_high", win_ones[0], 3);
    chk("center_D5_high", win_ones[1], 8);
    chk("center_D0_high", win_ones[2], 0);
    chk("center_D4_high", win_ones[3], 7);
    chk("center_done_per_period", win_done, 1);

    // Shadow update mid-period, then load coincident with the boundary
    cfg(0, 9, {4{8'd5}}, 4'b0000);
    wait_done(600, "shadow_sync");
    window(10, 3, {4{8'd8}});
    chk("shadow_current_keeps_5", win_ones[0], 5);
    window(10, 8, {4{8'd2}});
    chk("shadow_next_shows_8", win_ones[0], 8);
    window(10, -1, '0);
    chk("shadow_bypass_shows_2", win_ones[0], 2);

    // Polarity and enable
    cfg(0, 9, {4{8'd3}}, 4'b1010);
    wait_done(600, "pol_sync");
    window(10, -1, '0);
    chk("pol_ch0_high", win_ones[0], 3);
    chk("pol_ch1_high", win_ones[1], 7);
    en = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_levels", int'(pwm), 10);
    chk("idle_done", int'(done), 0);
    en = 1'b1;
    cycles_to_done(600, n);
    chk("reenable_first_period_len", n, 10);

    // P=0: period_done every enabled cycle
    cfg(0, 0, {4{8'd3}}, 4'b0000);
    wait_done(600, "p0_sync");
    window(5, -1, '0);
    chk("p0_done_every_cycle", win_done, 5);

    // P=255, D=255
    cfg(0, 255, {4{8'd255}}, 4'b0000);
    wait_done(600, "p255_sync");
    window(256, -1, '0);
    chk("p255_ch0_high", win_ones[0], 255);
    chk("p255_done_per_period", win_done, 1);

    // Reset mid-period with a pending configuration
    window(100, -1, '0);
    cfg(0, 9, {4{8'd200}}, 4'b0000);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_pwm", int'(pwm), 0);
    chk("midreset_done", int'(done), 0);
    rst_n = 1'b1;
    cycles_to_done(600, n);
    chk("after_reset_period_len", n, 256);
    window(10, -1, '0);
    chk("pending_discarded", win_done, 0);
    chk("after_reset_duty0", win_ones[0], 0);

    // Randomised traffic, checked every cycle by the model
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 63) == 0) en = ~en;
      load = ($urandom_range(0, 11) == 0);
      if (load) begin
        mode   = 1'($urandom_range(0, 1));
        period = W'($urandom_range(0, 12));
        for (int i = 0; i < N; i++) duty[i*W +: W] = W'($urandom_range(0, 14));
        pol    = N'($urandom_range(0, 15));
      end
    end
    @(negedge clk);
    load = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
